// File: rtl/ps2_scancode_decoder_if.sv
// Handshake bundle between the PS/2 frame receiver, this decoder and the event consumer.
// The master side drives frames in and accepts events out; the slave side is the decoder.
interface ps2_scancode_decoder_if;
    logic       frame_valid;
    logic [9:0] frame;
    logic       evt_valid;
    logic       evt_ready;
    logic [9:0] evt_data;

    modport master (
        output frame_valid,
        output frame,
        output evt_ready,
        input  evt_valid,
        input  evt_data
    );

    modport slave (
        input  frame_valid,
        input  frame,
        input  evt_ready,
        output evt_valid,
        output evt_data
    );
endinterface

// File: rtl/ps2_scancode_decoder.sv
// Turns raw PS/2 frames into {extended, release, code} key events and queues them
// in a first-word-fall-through FIFO with a registered head.
//
// state     | meaning
// ----------+----------------------------------------------
// S_IDLE    | no prefix seen; plain makes, silent replies
// S_EXT     | E0 seen; next code is an extended make
// S_BRK     | F0 seen; next code is a release
// S_EXT_BRK | E0 and F0 seen; next code is an extended release
module ps2_scancode_decoder #(
    parameter int FIFO_DEPTH      = 8,
    parameter bit SUPPRESS_REPEAT = 1'b1
) (
    input  logic                          clk,
    input  logic                          resetn,
    ps2_scancode_decoder_if.slave         bus,
    input  logic                          clr_status,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic [7:0]                    err_count
);
    localparam int             AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

    state_t        state_q, state_d;
    logic [7:0]    byte_in;
    logic          frame_good;
    logic          frame_bad;
    logic          is_silent;
    logic          emit, emit_ext, emit_rel;
    logic          push;
    logic [9:0]    push_data;
    logic [8:0]    last_make_q, last_make_d;

    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
    logic          pop, full, accept;
    logic [AW:0]   remain;

    assign byte_in    = bus.frame[8:1];
    assign frame_good = bus.frame_valid & ~bus.frame[0] & (^bus.frame[9:1]);
    assign frame_bad  = bus.frame_valid & ~frame_good;
    assign is_silent  = (byte_in == 8'hAA) || (byte_in == 8'hFA) || (byte_in == 8'hEE) ||
                        (byte_in == 8'hFE) || (byte_in == 8'h00) || (byte_in == 8'hFF);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            last_make_q <= '0;
        end else begin
            state_q     <= state_d;
            last_make_q <= last_make_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        emit     = 1'b0;
        emit_ext = 1'b0;
        emit_rel = 1'b0;
        if (frame_good) begin
            case (state_q)
                S_IDLE: begin
                    if (byte_in == 8'hE0)      state_d = S_EXT;
                    else if (byte_in == 8'hF0) state_d = S_BRK;
                    else if (!is_silent)       emit = 1'b1;
                end
                S_EXT: begin
                    if (byte_in == 8'hF0)      state_d = S_EXT_BRK;
                    else if (byte_in != 8'hE0) begin
                        emit     = 1'b1;
                        emit_ext = 1'b1;
                        state_d  = S_IDLE;
                    end
                end
                S_BRK: begin
                    if (byte_in == 8'hE0)      state_d = S_EXT_BRK;
                    else if (byte_in != 8'hF0) begin
                        emit     = 1'b1;
                        emit_rel = 1'b1;
                        state_d  = S_IDLE;
                    end
                end
                default: begin
                    if (byte_in != 8'hE0 && byte_in != 8'hF0) begin
                        emit     = 1'b1;
                        emit_ext = 1'b1;
                        emit_rel = 1'b1;
                        state_d  = S_IDLE;
                    end
                end
            endcase
        end
    end

    // A release of the held key re-arms it so the next make of that key is reported.
    always_comb begin
        last_make_d = last_make_q;
        push        = 1'b0;
        push_data   = {emit_ext, emit_rel, byte_in};
        if (emit) begin
            if (emit_rel) begin
                push = 1'b1;
                if ({emit_ext, byte_in} == last_make_q) last_make_d = '0;
            end else if (SUPPRESS_REPEAT && ({emit_ext, byte_in} == last_make_q)) begin
                push = 1'b0;
            end else begin
                push        = 1'b1;
                last_make_d = {emit_ext, byte_in};
            end
        end
    end

    assign pop     = bus.evt_valid & bus.evt_ready;
    assign full    = (fifo_count == FULL_CNT);
    assign accept  = push & (~full | pop);
    assign remain  = fifo_count - {{AW{1'b0}}, pop};
    assign rd_next = rd_ptr + AW'(pop);

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= push_data;
    end

    // The head only shows entries written before this edge, giving one extra cycle of latency.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_count    <= '0;
            bus.evt_valid <= 1'b0;
            bus.evt_data  <= '0;
            overflow      <= 1'b0;
            err_count     <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr <= rd_next;
            case ({accept, pop})
                2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
                2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
            bus.evt_valid <= (remain != '0);
            if (remain != '0) bus.evt_data <= mem[rd_next];

            if (clr_status)              overflow <= 1'b0;
            else if (push & full & ~pop) overflow <= 1'b1;

            if (clr_status)                          err_count <= '0;
            else if (frame_bad && err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Drives directed and random PS/2 frames into the decoder and compares every
// delivered event and status output against a prefix-flag reference model.
module tb_ps2_scancode_decoder;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       clr_status = 1'b0;
    logic [3:0] fifo_count;
    logic       overflow;
    logic [7:0] err_count;

    ps2_scancode_decoder_if bus();

    ps2_scancode_decoder #(.FIFO_DEPTH(DEPTH), .SUPPRESS_REPEAT(1'b1)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .bus        (bus),
        .clr_status (clr_status),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // reference model state
    logic [9:0] m_q[$];
    logic [9:0] seen[$];
    bit         m_ext, m_brk, m_ovf;
    logic [8:0] m_last;
    int         m_err;

    logic [7:0] keys[6] = '{8'h1C, 8'h1B, 8'h23, 8'h75, 8'h6B, 8'h29};
    logic [7:0] silent[6] = '{8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
    logic [7:0] many[10] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44, 8'h4D};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] mk_frame(input logic [7:0] d);
        return {~(^d), d, 1'b0};
    endfunction

    function automatic bit is_silent(input logic [7:0] b);
        foreach (silent[i]) if (silent[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_ext = 0; m_brk = 0; m_ovf = 0; m_last = '0; m_err = 0;
    endtask

    task automatic model_push(input logic [9:0] ev);
        if (m_q.size() < DEPTH) m_q.push_back(ev);
        else m_ovf = 1;
    endtask

    task automatic model_frame(input logic [9:0] fr);
        logic [7:0] b;
        logic [8:0] key;
        b = fr[8:1];
        if (fr[0] || !(^fr[9:1])) begin
            if (m_err < 255) m_err++;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else if (!m_ext && !m_brk && is_silent(b)) begin
        end else begin
            key = {m_ext, b};
            if (m_brk) begin
                if (key == m_last) m_last = '0;
                model_push({m_ext, 1'b1, b});
            end else if (key != m_last) begin
                m_last = key;
                model_push({m_ext, 1'b0, b});
            end
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    // Called just after a rising edge; occupies exactly one clock cycle.
    task automatic cycle(input logic fv, input logic [9:0] fr, input logic rdy, input logic clr);
        logic [9:0] exp;
        bus.frame_valid = fv;
        bus.frame       = fr;
        bus.evt_ready   = rdy;
        clr_status      = clr;
        @(negedge clk);
        if (bus.evt_valid && bus.evt_ready) begin
            seen.push_back(bus.evt_data);
            if (m_q.size() == 0) check("pop_unexpected", 1, 0);
            else begin
                exp = m_q.pop_front();
                check("evt_data", bus.evt_data, exp);
            end
        end
        if (fv) model_frame(fr);
        if (clr) begin m_err = 0; m_ovf = 0; end
        @(posedge clk);
        #1;
        bus.frame_valid = 1'b0;
        clr_status      = 1'b0;
        check("fifo_count", fifo_count, m_q.size());
        check("overflow", overflow, m_ovf);
        check("err_count", err_count, m_err);
    endtask

    task automatic drain();
        int n = 0;
        while (m_q.size() != 0 && n < 64) begin
            cycle(1'b0, '0, 1'b1, 1'b0);
            n++;
        end
        check("drain_empty", m_q.size(), 0);
    endtask

    task automatic do_reset();
        #2 resetn = 1'b0;
        #1;
        check("rst_evt_valid", bus.evt_valid, 0);
        check("rst_evt_data", bus.evt_data, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_err_count", err_count, 0);
        model_reset();
        @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [9:0] fr;
        int r;
        bus.frame_valid = 1'b0;
        bus.frame       = '0;
        bus.evt_ready   = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // latency of a single good make
        cycle(1'b1, 10'h038, 1'b0, 1'b0);
        check("lat_valid_e1", bus.evt_valid, 0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        check("lat_valid_e2", bus.evt_valid, 1);
        check("lat_data", bus.evt_data, 10'h01C);
        drain();

        // prefixes fold into one event
        seen.delete();
        cycle(1'b1, mk_frame(8'hF0), 1'b1, 1'b0);
        cycle(1'b1, mk_frame(8'h1C), 1'b1, 1'b0);
        cycle(1'b1, mk_frame(8'hE0), 1'b1, 1'b0);
        cycle(1'b1, mk_frame(8'hF0), 1'b1, 1'b0);
        cycle(1'b1, mk_frame(8'h75), 1'b1, 1'b0);
        drain();
        check("prefix_n", seen.size(), 2);
        if (seen.size() == 2) begin
            check("prefix_brk", seen[0], 10'h11C);
            check("prefix_ext_brk", seen[1], 10'h375);
        end

        // bad frames, saturation, clear
        cycle(1'b1, 10'h238, 1'b1, 1'b0);
        check("bad_err1", err_count, 1);
        for (int i = 0; i < 255; i++) cycle(1'b1, 10'h039, 1'b1, 1'b0);
        check("err_sat", err_count, 255);
        cycle(1'b1, 10'h238, 1'b1, 1'b1);
        check("err_clr_wins", err_count, 0);
        seen.delete();
        cycle(1'b1, 10'h038, 1'b1, 1'b0);
        drain();
        check("fsm_idle_after_bad", seen.size() == 1 && seen[0] == 10'h01C, 1);

        // repeat suppression
        cycle(1'b1, mk_frame(8'hF0), 1'b1, 1'b0);
        cycle(1'b1, mk_frame(8'h1C), 1'b1, 1'b0);
        drain();
        seen.delete();
        for (int i = 0; i < 3; i++) cycle(1'b1, mk_frame(8'h1C), 1'b1, 1'b0);
        cycle(1'b1, mk_frame(8'hF0), 1'b1, 1'b0);
        cycle(1'b1, mk_frame(8'h1C), 1'b1, 1'b0);
        cycle(1'b1, mk_frame(8'h1C), 1'b1, 1'b0);
        drain();
        check("rep_n", seen.size(), 3);
        if (seen.size() == 3) begin
            check("rep_0", seen[0], 10'h01C);
            check("rep_1", seen[1], 10'h11C);
            check("rep_2", seen[2], 10'h01C);
        end

        // fill past full, then push with pop at full
        for (int i = 0; i < 10; i++) cycle(1'b1, mk_frame(many[i]), 1'b0, 1'b0);
        check("full_count", fifo_count, 8);
        check("full_ovf", overflow, 1);
        cycle(1'b1, mk_frame(8'h4B), 1'b1, 1'b0);
        check("full_pushpop_count", fifo_count, 8);
        drain();
        cycle(1'b0, '0, 1'b1, 1'b1);
        check("ovf_clr", overflow, 0);

        // reset in the middle of a prefix sequence
        cycle(1'b1, mk_frame(8'hE0), 1'b0, 1'b0);
        cycle(1'b1, mk_frame(8'hF0), 1'b0, 1'b0);
        do_reset();
        cycle(1'b1, mk_frame(8'h75), 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        check("rst_mid_valid", bus.evt_valid, 1);
        check("rst_mid_data", bus.evt_data, 10'h075);
        drain();

        // random traffic
        for (int i = 0; i < 2000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 12)      fr = mk_frame(8'hE0);
            else if (r < 24) fr = mk_frame(8'hF0);
            else if (r < 30) fr = mk_frame(silent[$urandom_range(0, 5)]);
            else             fr = mk_frame(keys[$urandom_range(0, 5)]);
            r = $urandom_range(0, 99);
            if (r < 5)       fr = fr ^ 10'h200;
            else if (r < 8)  fr = fr | 10'h001;
            cycle($urandom_range(0, 99) < 45, fr, $urandom_range(0, 99) < 60,
                  $urandom_range(0, 99) < 2);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
- Sits directly downstream of the PS/2 keyboard receiver and consumes its captured 10-bit frames.
- Validates each frame's start bit and odd parity, and folds the E0 (extended) and F0 (break) prefixes into single key events.
- Optionally suppresses typematic repeats.
- Buffers key events in a small FIFO with a valid/ready interface toward the UART/CPU side.

Parameters:
- FIFO_DEPTH, 8, event FIFO entries; power of two, 2..64.
- SUPPRESS_REPEAT, 1, when 1 a repeated make of an already-held key is dropped.

Ports:
- clk  input  1  system clock
- resetn  input  1  asynchronous active-low reset
- frame_valid  input  1  one-cycle pulse: frame holds a complete received frame
- frame  input  10  bit0 start, bits8:1 data (LSB first), bit9 parity
- evt_valid  output  1  FIFO head valid
- evt_ready  input  1  consumer accepts head when evt_valid & evt_ready
- evt_data  output  10  {extended, release, code[7:0]} of FIFO head
- fifo_count  output  $clog2(FIFO_DEPTH)+1  occupied entries
- overflow  output  1  sticky; set when an event is dropped because the FIFO is full
- err_count  output  8  frames rejected for start/parity; saturates at 255
- clr_status  input  1  synchronous pulse: clears overflow and err_count

Behaviour:
- Reset (async, resetn=0):
  - evt_valid=0, evt_data=0, fifo_count=0, overflow=0, err_count=0.
  - Decoder FSM returns to IDLE; last_make cleared to 0 (no key held).
- Frame check, when frame_valid=1:
  - The frame is good iff frame[0]==0 and ^frame[9:1]==1 (odd parity over data+parity).
  - A bad frame increments err_count (saturating at 255), leaves the FSM state unchanged and produces no event.
- Decoder FSM (advances only on a good frame; byte = frame[8:1]):
  - IDLE: E0 -> EXT; F0 -> BRK; else emit {0,0,byte}, stay IDLE.
  - EXT: F0 -> EXT_BRK; E0 -> stay EXT; else emit {1,0,byte} -> IDLE.
  - BRK: E0 -> EXT_BRK; F0 -> stay BRK; else emit {0,1,byte} -> IDLE.
  - EXT_BRK: E0/F0 -> stay; else emit {1,1,byte} -> IDLE.
  - Bytes AA (self-test pass), FA (ack), EE, FE, 00, FF received in IDLE are consumed silently: no event, stay IDLE.
- Repeat suppression (SUPPRESS_REPEAT=1):
  - last_make holds {extended, code} of the last emitted make.
  - A make equal to last_make is dropped.
  - A break whose {extended, code} equals last_make clears last_make.
  - Any other emitted make overwrites last_make.
  - With SUPPRESS_REPEAT=0 every make is emitted.
- Latency: an event enters the FIFO on the clock edge after the frame_valid cycle. evt_valid rises one cycle after that (registered head, first-word-fall-through).
- FIFO:
  - Push and pop may occur in the same cycle; fifo_count is then unchanged.
  - On full with no simultaneous pop, the new event is dropped and overflow is set.
  - Push on full with a simultaneous pop is accepted.
  - When empty, evt_valid=0 and evt_data holds its previous value.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- clr_status and an increment/overflow in the same cycle: the clear wins, so the result is 0.
- Reset mid-sequence (e.g. after E0 F0): the FSM returns to IDLE, so the following byte decodes as a plain make.

Test Plan:
- Good frame data=1C (parity=0, frame=10'h038) -> one event 10'h01C; evt_valid high two cycles after the pulse; err_count=0.
- Frames F0 then 1C -> single event 10'h11C; no event for F0. Frames E0,F0,75 -> single event 10'h375.
- Frame 1C with parity bit flipped -> no event, err_count=1, FSM still IDLE. Then 255 more bad frames -> err_count=255. Then clr_status -> 0.
- SUPPRESS_REPEAT=1, makes 1C,1C,1C then F0 1C then 1C -> events 01C, 11C, 01C only.
- evt_ready=0, FIFO_DEPTH=8, ten distinct makes -> fifo_count=8, overflow=1, first eight events drained in order. Push with simultaneous pop at full -> accepted, count stays 8.
- resetn asserted after E0 F0, released, then frame 75 -> event 10'h075; all outputs 0 during reset.
